main_lane_forkjoin: RTL and testbench
=====================================

Name: main_lane_forkjoin

Overview:
- Parametrised fork/join buffer between the top-level host streams and NLANES independent kernelTop lane instances.
- Splits two wide input vectors into per-lane FIFOs so each lane can accept data on its own schedule.
- Collects per-lane results in per-lane FIFOs and emits an output vector only when every lane has a result. Lanes can therefore stall and skew independently, instead of sharing one ANDed valid/ready across all lanes.

Parameters:
- NLANES, 2: number of kernel lanes; 1..16.
- LANEW, 32: bits per lane element.
- DEPTH, 4: entries per lane FIFO; power of two, at least 2.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- ivalid  in  1  host input vector valid.
- iready  out  1  host input vector accepted when ivalid&iready.
- vin0  in  NLANES*LANEW  input stream 0; lane i occupies bits [i*LANEW +: LANEW].
- vin1  in  NLANES*LANEW  input stream 1; same lane packing.
- vout  out  NLANES*LANEW  output vector; same lane packing.
- ovalid  out  1  output vector valid.
- oready  in  1  downstream ready.
- k_ivalid  out  NLANES  per-lane valid to kernel lane i.
- k_iready  in  NLANES  per-lane ready from kernel lane i.
- k_vin0  out  NLANES*LANEW  lane i operand 0.
- k_vin1  out  NLANES*LANEW  lane i operand 1.
- k_vout  in  NLANES*LANEW  lane i result.
- k_ovalid  in  NLANES  lane i result valid.
- k_oready  out  NLANES  ready to lane i result.
- vec_count  out  32  number of output vectors emitted; wraps modulo 2^32.

Behaviour:
- Reset: rst is sampled on the clk rising edge and clears all FIFO pointers and counters and vec_count.
  - During and after reset: iready=1 and k_oready=all ones (FIFOs empty, not full); ovalid=0; k_ivalid=0.
  - vout/k_vin* hold don't-care data but must not be X-propagating into valid logic.
  - Reset mid-operation discards all buffered data with no partial output.
- Per-lane FIFO: AW=$clog2(DEPTH), occupancy counter 0..DEPTH, show-ahead, registered storage.
  - A word written in cycle t is visible at the FIFO head in cycle t+1.
  - Occupancy updates:
    - push only: occupancy +1.
    - pop only: occupancy -1.
    - push and pop in the same cycle: occupancy unchanged, pointers both advance.
  - Pointers wrap from DEPTH-1 to 0.
- Fork side:
  - iready = AND over lanes of (in_fifo[i] not full); combinational from registered state only, never from ivalid.
  - On ivalid&iready, every lane FIFO i pushes {vin1 lane i, vin0 lane i} in the same cycle.
  - k_ivalid[i] = in_fifo[i] not empty. k_vin0/k_vin1 lane i show that FIFO's head.
  - in_fifo[i] pops on k_ivalid[i]&k_iready[i]. Lanes pop independently.
  - Latency: input accepted in cycle t gives k_ivalid high at t+1.
- Join side:
  - k_oready[i] = out_fifo[i] not full.
  - out_fifo[i] pushes k_vout lane i on k_ovalid[i]&k_oready[i].
  - ovalid = AND over lanes of (out_fifo[i] not empty). vout lane i is out_fifo[i] head.
  - On ovalid&oready, all out FIFOs pop together and vec_count increments by 1.
  - A lane result written in cycle t can contribute to ovalid at t+1.
- Full/empty rules:
  - No push occurs when a FIFO is full; the ready definitions enforce this. If k_ovalid is high while k_oready is low, the lane must hold.
  - No pop occurs when empty.
  - Pop+push on a full FIFO is not possible on the fork side. On the join side, k_oready depends only on the full flag, so a full out FIFO refuses a push even when popping in the same cycle.
- Ordering: each lane preserves FIFO order. Output vector n consists of the nth result of every lane.
- Throughput: one vector per cycle sustained when all lanes and downstream are always ready.

Test Plan:
- NLANES=4, LANEW=32, DEPTH=4, kernels as 1-cycle adders, oready=1. Stream 8 vectors with lane i = (n*16+i, 1) -> vout lane i = n*16+i+1 for n=0..7, in order, back-to-back after fill; vec_count=8.
- Lane 2 k_iready=0 for 6 cycles, other lanes ready. Expected:
  - iready drops after in_fifo[2] holds 4 entries.
  - No ovalid until lane 2 produces a result.
  - All outputs remain correct and in order; no loss or duplication.
- oready=0 while pushing 10 vectors. Expected:
  - Out FIFOs fill to 4; k_oready=0; in FIFOs fill; iready=0.
  - After oready=1, all 10 outputs emerge in order.
- Assert rst for 1 cycle with 3 vectors buffered. Expected:
  - Next cycle: ovalid=0, k_ivalid=0, iready=1, vec_count=0.
  - Later traffic is correct with no stale data.
- NLANES=1, DEPTH=2, random ivalid/k_iready/k_ovalid/oready for 1000 cycles against a scoreboard -> zero mismatches; FIFO occupancy never exceeds 2.
- Drive vec_count to 0xFFFFFFFF via force, then emit 1 vector -> vec_count=0.

Source files
------------

// File: rtl/main_lane_forkjoin.sv
// Fork/join buffer between the host vector streams and NLANES kernel lanes.
// Each lane owns an input FIFO (fork side) and a result FIFO (join side), so
// lanes can stall and skew independently; a host vector is taken only when
// every input FIFO has room, and an output vector is presented only when
// every result FIFO holds a word.

// Show-ahead FIFO with registered storage and an explicit occupancy counter.
module main_lane_forkjoin_fifo #(
    parameter int W     = 32,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] wdata,
    input  logic         pop,
    output logic [W-1:0] rdata,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic [AW:0]   count;
    logic          push_ok;
    logic          pop_ok;

    // Guards make an illegal push/pop a no-op rather than corrupting state.
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;

    assign full  = (count == (AW+1)'(DEPTH));
    assign empty = (count == '0);
    assign rdata = mem[rptr];

    // Pointer and occupancy update; DEPTH is a power of two so the
    // pointers wrap from DEPTH-1 to 0 by natural overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push_ok) wptr <= wptr + AW'(1);
            if (pop_ok)  rptr <= rptr + AW'(1);
            case ({push_ok, pop_ok})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage has no reset; validity is carried by the occupancy counter only.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wptr] <= wdata;
    end
endmodule

// One lane: operand FIFO towards the kernel, result FIFO back from it.
module main_lane_forkjoin_lane #(
    parameter int LANEW = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_push,
    input  logic [LANEW-1:0] vin0,
    input  logic [LANEW-1:0] vin1,
    output logic             in_full,
    output logic             k_ivalid,
    input  logic             k_iready,
    output logic [LANEW-1:0] k_vin0,
    output logic [LANEW-1:0] k_vin1,
    input  logic [LANEW-1:0] k_vout,
    input  logic             k_ovalid,
    output logic             k_oready,
    input  logic             out_pop,
    output logic             out_empty,
    output logic [LANEW-1:0] vout
);
    logic                 in_empty;
    logic                 out_full;
    logic [2*LANEW-1:0]   in_head;

    assign k_ivalid = ~in_empty;
    assign k_oready = ~out_full;
    assign k_vin0   = in_head[LANEW-1:0];
    assign k_vin1   = in_head[2*LANEW-1:LANEW];

    main_lane_forkjoin_fifo #(.W(2*LANEW), .DEPTH(DEPTH)) u_in_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (in_push),
        .wdata ({vin1, vin0}),
        .pop   (k_ivalid & k_iready),
        .rdata (in_head),
        .full  (in_full),
        .empty (in_empty)
    );

    // k_oready is the plain not-full flag, so a full result FIFO refuses a
    // push even in a cycle where the join side pops it.
    main_lane_forkjoin_fifo #(.W(LANEW), .DEPTH(DEPTH)) u_out_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (k_ovalid & k_oready),
        .wdata (k_vout),
        .pop   (out_pop),
        .rdata (vout),
        .full  (out_full),
        .empty (out_empty)
    );
endmodule

module main_lane_forkjoin #(
    parameter int NLANES = 2,
    parameter int LANEW  = 32,
    parameter int DEPTH  = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    ivalid,
    output logic                    iready,
    input  logic [NLANES*LANEW-1:0] vin0,
    input  logic [NLANES*LANEW-1:0] vin1,
    output logic [NLANES*LANEW-1:0] vout,
    output logic                    ovalid,
    input  logic                    oready,
    output logic [NLANES-1:0]       k_ivalid,
    input  logic [NLANES-1:0]       k_iready,
    output logic [NLANES*LANEW-1:0] k_vin0,
    output logic [NLANES*LANEW-1:0] k_vin1,
    input  logic [NLANES*LANEW-1:0] k_vout,
    input  logic [NLANES-1:0]       k_ovalid,
    output logic [NLANES-1:0]       k_oready,
    output logic [31:0]             vec_count
);
    logic [NLANES-1:0] in_full;
    logic [NLANES-1:0] out_empty;
    logic              in_push;
    logic              out_pop;

    // Readiness/validity come from FIFO flags only, never from ivalid/oready,
    // so there is no combinational path host-in to host-out.
    assign iready  = &(~in_full);
    assign ovalid  = &(~out_empty);
    assign in_push = ivalid & iready;
    assign out_pop = ovalid & oready;

    for (genvar i = 0; i < NLANES; i++) begin : g_lane
        main_lane_forkjoin_lane #(.LANEW(LANEW), .DEPTH(DEPTH)) u_lane (
            .clk       (clk),
            .rst       (rst),
            .in_push   (in_push),
            .vin0      (vin0[i*LANEW +: LANEW]),
            .vin1      (vin1[i*LANEW +: LANEW]),
            .in_full   (in_full[i]),
            .k_ivalid  (k_ivalid[i]),
            .k_iready  (k_iready[i]),
            .k_vin0    (k_vin0[i*LANEW +: LANEW]),
            .k_vin1    (k_vin1[i*LANEW +: LANEW]),
            .k_vout    (k_vout[i*LANEW +: LANEW]),
            .k_ovalid  (k_ovalid[i]),
            .k_oready  (k_oready[i]),
            .out_pop   (out_pop),
            .out_empty (out_empty[i]),
            .vout      (vout[i*LANEW +: LANEW])
        );
    end

    // Count emitted output vectors, wrapping modulo 2^32.
    always_ff @(posedge clk) begin
        if (rst)          vec_count <= '0;
        else if (out_pop) vec_count <= vec_count + 32'd1;
    end
endmodule

// File: tb/tb_main_lane_forkjoin.sv
// Bench for main_lane_forkjoin: a 4-lane/depth-4 instance driven with directed
// vectors, and a 1-lane/depth-2 instance driven randomly. Kernels are modelled
// as one-cycle adders. Expected vectors go into queues when issued; monitors
// pop and compare whenever an output vector is consumed.
module tb_main_lane_forkjoin;
    localparam int NL = 4;
    localparam int W  = 32;
    localparam int NV = NL*W;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [NV-1:0] act, input logic [NV-1:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // ---------------- instance A: 4 lanes, depth 4 ----------------
    logic           ivalid_a = 1'b0, oready_a = 1'b1;
    logic           iready_a, ovalid_a;
    logic [NV-1:0]  vin0_a = '0, vin1_a = '0;
    logic [NV-1:0]  vout_a, k_vin0_a, k_vin1_a, k_vout_a;
    logic [NL-1:0]  k_ivalid_a, k_iready_a, k_ovalid_a, k_oready_a;
    logic [31:0]    vec_count_a;

    main_lane_forkjoin #(.NLANES(NL), .LANEW(W), .DEPTH(4)) dut_a (
        .clk(clk), .rst(rst), .ivalid(ivalid_a), .iready(iready_a),
        .vin0(vin0_a), .vin1(vin1_a), .vout(vout_a), .ovalid(ovalid_a),
        .oready(oready_a), .k_ivalid(k_ivalid_a), .k_iready(k_iready_a),
        .k_vin0(k_vin0_a), .k_vin1(k_vin1_a), .k_vout(k_vout_a),
        .k_ovalid(k_ovalid_a), .k_oready(k_oready_a), .vec_count(vec_count_a)
    );

    // one-cycle adder kernels, stall_a[i] forces lane i not ready
    logic [NL-1:0]        stall_a = '0;
    logic [NL-1:0]        kv_a;
    logic [NL-1:0][W-1:0] kres_a;
    always_comb begin
        k_iready_a = '0;
        for (int i = 0; i < NL; i++)
            k_iready_a[i] = !stall_a[i] && (!kv_a[i] || k_oready_a[i]);
    end
    assign k_ovalid_a = kv_a;
    assign k_vout_a   = kres_a;
    always @(posedge clk) begin
        for (int i = 0; i < NL; i++) begin
            if (rst) kv_a[i] <= 1'b0;
            else if (k_ivalid_a[i] && k_iready_a[i]) begin
                kv_a[i]   <= 1'b1;
                kres_a[i] <= k_vin0_a[i*W +: W] + k_vin1_a[i*W +: W];
            end else if (k_oready_a[i]) kv_a[i] <= 1'b0;
        end
    end

    logic [NV-1:0] exp_q_a[$];
    int acc_a = 0;
    int first_a = -1, last_a = -1;

    // monitor A: compare each consumed output vector
    always @(negedge clk) begin
        if (!rst && ovalid_a && oready_a) begin
            if (exp_q_a.size() == 0) begin
                checks++; failures++;
                $display("FAIL a_unexpected_output actual=%h required=none", vout_a);
            end else chk("a_vout", vout_a, exp_q_a.pop_front());
            if (first_a < 0) first_a = cyc;
            last_a = cyc;
        end
    end

    function automatic logic [NV-1:0] lanes(input int base, input int step);
        logic [NV-1:0] r;
        for (int i = 0; i < NL; i++) r[i*W +: W] = 32'(base + step*i);
        return r;
    endfunction

    task automatic send_a(input logic [NV-1:0] a, input logic [NV-1:0] b, input logic [NV-1:0] e);
        int t = 0;
        ivalid_a = 1'b1; vin0_a = a; vin1_a = b;
        while (!iready_a && t < 200) begin @(posedge clk); #1; t++; end
        if (t >= 200) begin
            checks++; failures++;
            $display("FAIL a_send_timeout actual=blocked required=accepted");
        end else begin
            @(posedge clk); #1;
            acc_a++;
            exp_q_a.push_back(e);
        end
        ivalid_a = 1'b0;
    endtask

    task automatic drain_a();
        int t = 0;
        while (exp_q_a.size() != 0 && t < 200) begin @(posedge clk); #1; t++; end
        checks++;
        if (t >= 200) begin
            failures++;
            $display("FAIL a_drain_timeout actual=%0d required=0", exp_q_a.size());
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    // ---------------- instance B: 1 lane, depth 2 ----------------
    logic        ivalid_b = 1'b0, oready_b = 1'b1;
    logic        iready_b, ovalid_b;
    logic [31:0] vin0_b = '0, vin1_b = '0;
    logic [31:0] vout_b, k_vin0_b, k_vin1_b, k_vout_b, vec_count_b;
    logic        k_ivalid_b, k_iready_b, k_ovalid_b, k_oready_b;

    main_lane_forkjoin #(.NLANES(1), .LANEW(32), .DEPTH(2)) dut_b (
        .clk(clk), .rst(rst), .ivalid(ivalid_b), .iready(iready_b),
        .vin0(vin0_b), .vin1(vin1_b), .vout(vout_b), .ovalid(ovalid_b),
        .oready(oready_b), .k_ivalid(k_ivalid_b), .k_iready(k_iready_b),
        .k_vin0(k_vin0_b), .k_vin1(k_vin1_b), .k_vout(k_vout_b),
        .k_ovalid(k_ovalid_b), .k_oready(k_oready_b), .vec_count(vec_count_b)
    );

    // adder kernel with random input stall and random output presentation;
    // once offered, a result is held until accepted
    logic        stall_b = 1'b0, gate_b = 1'b1, kv_b, held_b;
    logic [31:0] kres_b;
    assign k_ovalid_b = kv_b && (gate_b || held_b);
    assign k_iready_b = !stall_b && (!kv_b || (k_ovalid_b && k_oready_b));
    assign k_vout_b   = kres_b;
    always @(posedge clk) begin
        if (rst) begin
            kv_b <= 1'b0; held_b <= 1'b0;
        end else begin
            held_b <= k_ovalid_b && !k_oready_b;
            if (k_ivalid_b && k_iready_b) begin
                kv_b <= 1'b1; kres_b <= k_vin0_b + k_vin1_b;
            end else if (k_ovalid_b && k_oready_b) kv_b <= 1'b0;
        end
    end

    logic [31:0] exp_q_b[$];
    int acc_b = 0;

    // scoreboard B: record the sum of every accepted host word
    always @(negedge clk) begin
        if (rst) begin
            exp_q_b.delete(); acc_b = 0;
        end else if (ivalid_b && iready_b) begin
            exp_q_b.push_back(vin0_b + vin1_b); acc_b++;
        end
    end

    // monitor B: compare each consumed output word
    always @(negedge clk) begin
        if (!rst && ovalid_b && oready_b) begin
            if (exp_q_b.size() == 0) begin
                checks++; failures++;
                $display("FAIL b_unexpected_output actual=%h required=none", vout_b);
            end else chk("b_vout", NV'(vout_b), NV'(exp_q_b.pop_front()));
        end
    end

    // occupancy model B: flags must track handshake-derived occupancy (max 2)
    int occ_in_b = 0, occ_out_b = 0;
    always @(negedge clk) begin
        if (rst) begin
            occ_in_b = 0; occ_out_b = 0;
        end else begin
            checks++;
            if (k_ivalid_b !== (occ_in_b != 0) || iready_b !== (occ_in_b < 2) ||
                ovalid_b !== (occ_out_b != 0) || k_oready_b !== (occ_out_b < 2) ||
                occ_in_b > 2 || occ_out_b > 2) begin
                failures++;
                $display("FAIL b_occupancy actual=iready%b/k_ivalid%b/k_oready%b/ovalid%b required=occ_in%0d/occ_out%0d",
                         iready_b, k_ivalid_b, k_oready_b, ovalid_b, occ_in_b, occ_out_b);
            end
            occ_in_b  += int'(ivalid_b && iready_b) - int'(k_ivalid_b && k_iready_b);
            occ_out_b += int'(k_ovalid_b && k_oready_b) - int'(ovalid_b && oready_b);
        end
    end

    // ---------------- directed + random sequence ----------------
    initial begin
        int base;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        chk("rst_iready", NV'(iready_a), NV'(1));
        chk("rst_ovalid", NV'(ovalid_a), NV'(0));
        chk("rst_k_ivalid", NV'(k_ivalid_a), NV'(0));
        chk("rst_k_oready", NV'(k_oready_a), NV'(4'hF));
        chk("rst_vec_count", NV'(vec_count_a), NV'(0));

        // 8 vectors streamed, lane i = (n*16+i) + 1
        first_a = -1;
        for (int n = 0; n < 8; n++) send_a(lanes(n*16, 1), lanes(1, 0), lanes(n*16+1, 1));
        drain_a();
        chk("stream_back_to_back", NV'(last_a - first_a), NV'(7));
        chk("stream_vec_count", NV'(vec_count_a), NV'(8));

        // lane 2 stalled for 6 cycles
        stall_a = 4'b0100;
        base = acc_a;
        fork
            for (int n = 0; n < 6; n++)
                send_a(lanes(256+n*16, 1), lanes(n, 0), lanes(256+n*17, 1));
            begin
                repeat (6) @(posedge clk);
                #1;
                chk("stall_iready", NV'(iready_a), NV'(0));
                chk("stall_ovalid", NV'(ovalid_a), NV'(0));
                chk("stall_accepted", NV'(acc_a - base), NV'(4));
                stall_a = '0;
            end
        join
        drain_a();
        chk("stall_vec_count", NV'(vec_count_a), NV'(14));

        // downstream blocked while 10 vectors offered; 9 fit
        oready_a = 1'b0;
        base = acc_a;
        fork
            for (int n = 0; n < 10; n++)
                send_a(lanes(1024+n*16, 1), lanes(7, 0), lanes(1031+n*16, 1));
            begin
                repeat (30) @(posedge clk);
                #1;
                chk("bp_k_oready", NV'(k_oready_a), NV'(0));
                chk("bp_iready", NV'(iready_a), NV'(0));
                chk("bp_ovalid", NV'(ovalid_a), NV'(1));
                chk("bp_accepted", NV'(acc_a - base), NV'(9));
                oready_a = 1'b1;
            end
        join
        drain_a();
        chk("bp_vec_count", NV'(vec_count_a), NV'(24));

        // reset with 3 vectors buffered
        oready_a = 1'b0;
        for (int n = 0; n < 3; n++) send_a(lanes(4096+n, 1), lanes(0, 0), lanes(4096+n, 1));
        repeat (4) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        exp_q_a.delete();
        chk("midrst_ovalid", NV'(ovalid_a), NV'(0));
        chk("midrst_k_ivalid", NV'(k_ivalid_a), NV'(0));
        chk("midrst_iready", NV'(iready_a), NV'(1));
        chk("midrst_vec_count", NV'(vec_count_a), NV'(0));
        oready_a = 1'b1;
        send_a(lanes(8192, 3), lanes(5, 1), lanes(8197, 4));
        send_a(lanes(100, 2), lanes(100, 2), lanes(200, 4));
        drain_a();
        chk("postrst_vec_count", NV'(vec_count_a), NV'(2));

        // vec_count wrap
        force dut_a.vec_count = 32'hFFFF_FFFF;
        @(posedge clk);
        #1 release dut_a.vec_count;
        send_a(lanes(1, 1), lanes(1, 1), lanes(2, 2));
        drain_a();
        chk("wrap_vec_count", NV'(vec_count_a), NV'(0));

        // random traffic on the single-lane, depth-2 instance
        for (int c = 0; c < 1000; c++) begin
            @(posedge clk);
            #1;
            ivalid_b = 1'($urandom_range(0, 1));
            vin0_b   = $urandom;
            vin1_b   = $urandom;
            stall_b  = ($urandom_range(0, 3) == 0);
            gate_b   = 1'($urandom_range(0, 1));
            oready_b = ($urandom_range(0, 2) != 0);
        end
        ivalid_b = 1'b0; stall_b = 1'b0; gate_b = 1'b1; oready_b = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        chk("rand_queue_empty", NV'(exp_q_b.size()), NV'(0));
        chk("rand_vec_count", NV'(vec_count_b), NV'(acc_b));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // hard time bound
    initial begin
        #400000;
        failures++;
        $display("FAIL watchdog actual=running required=finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end
endmodule
